// File: rtl/inst_prefetch_buf.sv
// Halfword-granular instruction prefetch buffer: accepts 32-bit flash words and
// presents one 16-bit or 32-bit Thumb-2 instruction at a time to the decoder.
module inst_prefetch_buf #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_word,
    output logic             fetch_ready,
    input  logic             flush,
    input  logic             flush_odd,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic             inst_is32,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [15:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_skip;

    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_skip_nxt;

    logic [15:0]      w_hw0;
    logic [15:0]      w_hw1;
    logic             w_head32;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_push_amt;
    logic [CNT_W-1:0] w_pop_amt;

    assign w_hw0    = r_mem[r_rptr];
    assign w_hw1    = r_mem[r_rptr + PTR_W'(1)];
    assign w_head32 = (w_hw0[15:11] == 5'b11101) || (w_hw0[15:11] == 5'b11110) ||
                      (w_hw0[15:11] == 5'b11111);

    // Room for a full word is required even when only the upper half will be kept.
    assign fetch_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign inst_valid  = (r_count >= CNT_W'(2)) || ((r_count == CNT_W'(1)) && !w_head32);
    assign inst_is32   = inst_valid && w_head32;
    assign inst        = !inst_valid ? 32'h0 :
                         (w_head32 ? {w_hw0, w_hw1} : {16'h0000, w_hw0});
    assign count       = r_count;

    assign w_push     = fetch_valid && fetch_ready && !flush;
    assign w_pop      = inst_valid && inst_ready && !flush;
    assign w_push_amt = w_push ? (r_skip ? CNT_W'(1) : CNT_W'(2)) : CNT_W'(0);
    assign w_pop_amt  = w_pop ? (w_head32 ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        w_skip_nxt  = r_skip;
        if (flush) begin
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_count_nxt = '0;
            w_skip_nxt  = flush_odd;
        end else begin
            w_wptr_nxt  = r_wptr + PTR_W'(w_push_amt);
            w_rptr_nxt  = r_rptr + PTR_W'(w_pop_amt);
            w_count_nxt = r_count + w_push_amt - w_pop_amt;
            if (w_push) begin
                w_skip_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_skip  <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // Storage is left uncleared on reset/flush; count alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            if (r_skip) begin
                r_mem[r_wptr] <= fetch_word[31:16];
            end else begin
                r_mem[r_wptr]              <= fetch_word[15:0];
                r_mem[r_wptr + PTR_W'(1)]  <= fetch_word[31:16];
            end
        end
    end

endmodule
